// File: rtl/inv_sbox_layer.sv
// ============================================================================
// Module: inv_sbox_layer
//
// Iterative inverse S-box layer for the decryption datapath of a 4-bit
// S-box cipher. It sits between the inverse permutation layer and round-key
// addition. A state word of NIBBLES nibbles is accepted and every nibble v is
// replaced with Sinv(v), LANES nibbles per clock. The result is handed on
// through a valid/ready handshake.
//
//   Sinv[0..F] = 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A
//
// Parameters
//   NIBBLES  number of 4-bit nibbles in the state word (W = 4*NIBBLES)
//   LANES    Sinv instances applied per cycle; must divide NIBBLES
//
// Ports
//   clk        in   1  single clock, rising edge
//   rst        in   1  asynchronous, active-low reset
//   in_valid   in   1  in_data holds a valid state word
//   in_ready   out  1  block can accept a word this cycle
//   in_data    in   W  state word, nibble i = in_data[4i+3:4i]
//   out_valid  out  1  out_data holds a completed result
//   out_ready  in   1  consumer accepts out_data this cycle
//   out_data   out  W  transformed state word
// ============================================================================
module inv_sbox_layer #(
   parameter int NIBBLES = 16,
   parameter int LANES   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] out_data
);

   localparam int W      = 4 * NIBBLES;
   localparam int GROUPS = NIBBLES / LANES;
   localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(GROUPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     work;
   logic [W-1:0]     work_next;
   logic             armed;

   // Inverse S-box lookup for a single nibble.
   function automatic logic [3:0] sinv(input logic [3:0] v);
      logic [3:0] r;
      case (v)
         4'h0: r = 4'h5;
         4'h1: r = 4'hE;
         4'h2: r = 4'hF;
         4'h3: r = 4'h8;
         4'h4: r = 4'hC;
         4'h5: r = 4'h1;
         4'h6: r = 4'h2;
         4'h7: r = 4'hD;
         4'h8: r = 4'hB;
         4'h9: r = 4'h4;
         4'hA: r = 4'h6;
         4'hB: r = 4'h3;
         4'hC: r = 4'h0;
         4'hD: r = 4'h7;
         4'hE: r = 4'h9;
         default: r = 4'hA;
      endcase
      return r;
   endfunction

   // Next value of the working register while BUSY: only the group selected
   // by cnt is substituted, every other nibble is carried through unchanged.
   always_comb begin
      work_next = work;
      for (int l = 0; l < LANES; l++) begin
         work_next[(int'(cnt) * LANES + l) * 4 +: 4] =
            sinv(work[(int'(cnt) * LANES + l) * 4 +: 4]);
      end
   end

   // Control FSM and datapath. The working register doubles as the output
   // register, so out_data only moves on an accept edge or a BUSY edge and is
   // held in DONE while the consumer stalls. armed keeps in_ready low while
   // reset is applied and until the first edge after its release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         work      <= '0;
         out_valid <= 1'b0;
         armed     <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               if (in_valid && in_ready) begin
                  work  <= in_data;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end

            BUSY: begin
               work <= work_next;
               if (cnt == LAST_GROUP) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     work  <= in_data;
                     cnt   <= '0;
                     state <= BUSY;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // The only combinational path from an input to an output: a finished
   // result being drained frees the block to take the next word on the same
   // edge.
   assign in_ready = armed & ((state == IDLE) | ((state == DONE) & out_ready));
   assign out_data = work;

endmodule

// File: tb/tb_inv_sbox_layer.sv
// ============================================================================
// Testbench: tb_inv_sbox_layer
//
// Three instances of inv_sbox_layer (LANES = 1, 4, 16, NIBBLES = 16) share
// clock and reset. Expected results come from a model that inverts the
// forward S-box table. They are pushed into a scoreboard when a word is
// accepted. A per-instance monitor pops them when the result is transferred,
// and it also checks latency, hold-under-backpressure and handshake levels.
// ============================================================================
module tb_inv_sbox_layer;

   localparam int NINST = 3;

   typedef struct {
      int          inst;
      logic [63:0] data;
      int          acceptEdge;
   } entry_t;

   // Forward S-box; the reference inverse is derived from it.
   localparam logic [3:0] FWD [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   logic        clk;
   logic        rst;
   logic        inValid  [NINST];
   logic        inReady  [NINST];
   logic [63:0] inData   [NINST];
   logic        outValid [NINST];
   logic        outReady [NINST];
   logic [63:0] outData  [NINST];

   entry_t sb[$];
   int     pending     [NINST];
   int     lastAccept  [NINST];
   int     prevAccept  [NINST];
   int     cycle;
   int     checks;
   int     passes;

   // Device instances, one per lane count.
   for (genvar g = 0; g < NINST; g++) begin : gInst
      localparam int L = (g == 0) ? 1 : (g == 1) ? 4 : 16;
      localparam int G = 16 / L;

      inv_sbox_layer #(.NIBBLES(16), .LANES(L)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (inValid[g]),
         .in_ready  (inReady[g]),
         .in_data   (inData[g]),
         .out_valid (outValid[g]),
         .out_ready (outReady[g]),
         .out_data  (outData[g])
      );

      // Output monitor: compares the head scoreboard entry for this instance
      // whenever out_valid is high, and pops it on a transfer.
      always @(negedge clk) begin : monitor
         int  idx;
         bit  seen;
         bit  popped;
         if (!rst) begin
            for (int i = sb.size() - 1; i >= 0; i--)
               if (sb[i].inst == g) sb.delete(i);
            pending[g] = 0;
            seen       = 0;
            popped     = 0;
         end else begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
               if (idx < 0 && sb[i].inst == g) idx = i;
            if (popped) begin
               checkOutput($sformatf("pulse%0d", g), 64'(outValid[g]), 64'd0);
               popped = 0;
            end
            if (outValid[g]) begin
               if (idx < 0) begin
                  checkOutput($sformatf("spurious%0d", g), 64'd1, 64'd0);
               end else begin
                  if (!seen) begin
                     checkOutput($sformatf("latency%0d", g),
                                 64'(cycle - sb[idx].acceptEdge), 64'(G));
                     seen = 1;
                  end
                  checkOutput($sformatf("data%0d", g), outData[g], sb[idx].data);
                  checkOutput($sformatf("doneReady%0d", g),
                              64'(inReady[g]), 64'(outReady[g]));
                  if (outReady[g]) begin
                     sb.delete(idx);
                     pending[g] = pending[g] - 1;
                     seen   = 0;
                     popped = 1;
                  end
               end
            end else if (idx >= 0 && sb[idx].acceptEdge <= cycle) begin
               checkOutput($sformatf("busyReady%0d", g), 64'(inReady[g]), 64'd0);
            end
         end
      end
   end

   // Clock and edge counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Counts one comparison and reports it if it does not match.
   task automatic checkOutput(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Reference model: invert each nibble by searching the forward table.
   function automatic logic [63:0] sinvWord(input logic [63:0] x);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            if (FWD[j] == x[4*i +: 4]) r[4*i +: 4] = 4'(j);
      return r;
   endfunction

   // Offers one word to instance k until it is accepted, recording the
   // expected result. in_data is scrambled afterwards.
   task automatic applyStimulus(input int k, input logic [63:0] data,
                                input logic [63:0] exp);
      bit accepted;
      accepted   = 0;
      inValid[k] = 1'b1;
      inData[k]  = data;
      for (int t = 0; t < 200 && !accepted; t++) begin
         @(negedge clk);
         if (inReady[k]) begin
            sb.push_back('{inst: k, data: exp, acceptEdge: cycle + 1});
            pending[k]    = pending[k] + 1;
            prevAccept[k] = lastAccept[k];
            lastAccept[k] = cycle + 1;
            accepted      = 1;
         end
      end
      if (!accepted) checkOutput($sformatf("acceptTimeout%0d", k), 64'd0, 64'd1);
      @(posedge clk);
      #1;
      inValid[k] = 1'b0;
      inData[k]  = {$urandom, $urandom};
   endtask

   // Waits until every result of instance k has been transferred.
   task automatic waitDrain(input int k);
      int t;
      t = 0;
      while (pending[k] != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      if (pending[k] != 0) checkOutput($sformatf("drainTimeout%0d", k), 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Main sequence.
   initial begin : main
      logic [63:0] w;
      bit          gotValid;
      checks = 0;
      passes = 0;
      rst    = 1'b0;
      for (int k = 0; k < NINST; k++) begin
         inValid[k]    = 1'b0;
         inData[k]     = '0;
         outReady[k]   = 1'b1;
         pending[k]    = 0;
         lastAccept[k] = 0;
         prevAccept[k] = 0;
      end

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NINST; k++) begin
         checkOutput($sformatf("rstValid%0d", k), 64'(outValid[k]), 64'd0);
         checkOutput($sformatf("rstData%0d", k), outData[k], 64'd0);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rstReady", 64'(inReady[0]), 64'd1);

      $display("[TB] known vectors");
      applyStimulus(0, 64'h0123456789ABCDEF, 64'h5EF8C12DB463079A);
      waitDrain(0);
      applyStimulus(0, 64'hC56B90AD3EF84712, 64'h0123456789ABCDEF);
      waitDrain(0);
      applyStimulus(0, 64'h0, 64'h5555555555555555);
      waitDrain(0);

      $display("[TB] backpressure");
      outReady[0] = 1'b0;
      w = {$urandom, $urandom};
      applyStimulus(0, w, sinvWord(w));
      gotValid = 0;
      for (int t = 0; t < 100 && !gotValid; t++) begin
         @(negedge clk);
         gotValid = outValid[0];
      end
      checkOutput("bpValid", 64'(gotValid), 64'd1);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("bpReady", 64'(inReady[0]), 64'd0);
      outReady[0] = 1'b1;
      waitDrain(0);
      checkOutput("bpIdle", 64'(inReady[0]), 64'd1);

      $display("[TB] back-to-back");
      w = {$urandom, $urandom};
      applyStimulus(0, w, sinvWord(w));
      w = {$urandom, $urandom};
      applyStimulus(0, w, sinvWord(w));
      waitDrain(0);
      checkOutput("b2bGap", 64'(lastAccept[0] - prevAccept[0]), 64'd17);

      $display("[TB] reset mid-operation");
      applyStimulus(0, 64'hFEDCBA9876543210, sinvWord(64'hFEDCBA9876543210));
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midRstValid", 64'(outValid[0]), 64'd0);
      checkOutput("midRstData", outData[0], 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(0, 64'h0123456789ABCDEF, 64'h5EF8C12DB463079A);
      waitDrain(0);

      $display("[TB] wider lanes");
      for (int k = 1; k < NINST; k++) begin
         applyStimulus(k, 64'h0123456789ABCDEF, 64'h5EF8C12DB463079A);
         waitDrain(k);
      end

      $display("[TB] nibble sweep");
      for (int k = 0; k < NINST; k++) begin
         for (int v = 0; v < 16; v++) begin
            for (int p = 0; p < 16; p++) w[4*p +: 4] = 4'((v + p) % 16);
            applyStimulus(k, w, sinvWord(w));
         end
         for (int n = 0; n < 4; n++) begin
            w = {$urandom, $urandom};
            applyStimulus(k, w, sinvWord(w));
         end
         waitDrain(k);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
